genesis_pad_scanner: RTL and testbench



---
 rtl/genesis_pad_pkg.sv | 44 ++++
 rtl/genesis_pad_scanner_if.sv | 32 +++
 rtl/pad_input_sync.sv | 28 ++
 rtl/genesis_pad_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_genesis_pad_scanner.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/genesis_pad_pkg.sv
// Shared types and constants for the Genesis pad scanner.
// Build option: GENESIS_SIX_BUTTON_EN adds the 6-button phases (8 phases instead of 2).
package genesis_pad_pkg;

   // Scanner FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PHASE   = 2'd1,
      ST_PUBLISH = 2'd2
   } pad_state_e;

   localparam int NUM_BUTTONS = 12;

   // Bit positions inside the published button word
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_START = 7;
   localparam int BTN_X     = 8;
   localparam int BTN_Y     = 9;
   localparam int BTN_Z     = 10;
   localparam int BTN_MODE  = 11;

   // Bit positions of the six raw pad pins inside the synchronizer vector
   localparam int NUM_PINS  = 6;
   localparam int PIN_UP    = 0;
   localparam int PIN_DOWN  = 1;
   localparam int PIN_LEFT  = 2;
   localparam int PIN_RIGHT = 3;
   localparam int PIN_AB    = 4;
   localparam int PIN_SC    = 5;

   // Select phases per scan
`ifdef GENESIS_SIX_BUTTON_EN
   localparam int NUM_PHASES = 8;
`else
   localparam int NUM_PHASES = 2;
`endif

endpackage

// File: rtl/genesis_pad_scanner_if.sv
// Pad-side pins and snapshot outputs of the Genesis pad scanner.
// buttons_valid is a one-cycle strobe with no ready: buttons, pad_present and
// six_button change only in the cycle the strobe is high and hold until the next one.
interface genesis_pad_scanner_if;
   import genesis_pad_pkg::*;

   logic                   up_z;
   logic                   down_y;
   logic                   left_x;
   logic                   right;
   logic                   a_b;
   logic                   start_c;
   logic                   select_out;
   logic [NUM_BUTTONS-1:0] buttons;
   logic                   buttons_valid;
   logic                   pad_present;
   logic                   six_button;
   pad_state_e             dbg_state;

   // Scanner side
   modport master (
      input  up_z, down_y, left_x, right, a_b, start_c,
      output select_out, buttons, buttons_valid, pad_present, six_button, dbg_state
   );

   // Pad / consumer side
   modport slave (
      output up_z, down_y, left_x, right, a_b, start_c,
      input  select_out, buttons, buttons_valid, pad_present, six_button, dbg_state
   );

endinterface

// File: rtl/pad_input_sync.sv
// Two-flop synchronizer for asynchronous pad pins. Resets to all ones, the
// idle (released) level of the active-low pins.
module pad_input_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two register stages to settle metastability
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/genesis_pad_scanner.sv
// Genesis DB-9 pad scanner: drives select through a timed phase sequence once per
// frame, captures the synchronized pins mid-phase and publishes one snapshot.
// Build option: GENESIS_SIX_BUTTON_EN enables 6-button detection (X/Y/Z/Mode).
module genesis_pad_scanner
   import genesis_pad_pkg::*;
#(
   parameter int STEP_CYCLES   = 500,
   parameter int SETTLE_CYCLES = 100,
   parameter int FRAME_CYCLES  = 416666
) (
   input  logic                  clk,
   input  logic                  reset,
   genesis_pad_scanner_if.master pad
);

   localparam int STEP_W  = (STEP_CYCLES  > 1) ? $clog2(STEP_CYCLES)  : 1;
   localparam int FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int PH_W    = $clog2(NUM_PHASES);

   localparam logic [STEP_W-1:0]  STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0]  SAMPLE_STEP = STEP_W'(SETTLE_CYCLES - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(FRAME_CYCLES - 1);
   localparam logic [PH_W-1:0]    PH_LAST     = PH_W'(NUM_PHASES - 1);

   logic [NUM_PINS-1:0]    pins_raw;
   logic [NUM_PINS-1:0]    pins_s;
   logic [NUM_PINS-1:0]    pressed;

   pad_state_e             state_q, state_d;
   logic [PH_W-1:0]        ph_q, ph_d;
   logic [STEP_W-1:0]      step_q, step_d;
   logic                   sel_q, sel_d;
   logic [FRAME_W-1:0]     frame_q;
   logic                   sample;
   logic                   publish;

   logic [NUM_BUTTONS-1:0] shadow_q;
   logic                   present_q;
   logic [NUM_BUTTONS-1:0] buttons_q;
   logic                   valid_q;
   logic                   pad_present_q;

   assign pins_raw = {pad.start_c, pad.a_b, pad.right, pad.left_x, pad.down_y, pad.up_z};

   pad_input_sync #(.WIDTH(NUM_PINS)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (pins_raw),
      .q_o   (pins_s)
   );

   // Pins are active-low; everything downstream works in pressed = 1
   assign pressed = ~pins_s;

   // Free-running frame counter; a zero value marks the start of a frame
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q <= '0;
      end else if (frame_q == FRAME_LAST) begin
         frame_q <= '0;
      end else begin
         frame_q <= frame_q + 1'b1;
      end
   end

   // FSM and scan counters state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         step_q  <= '0;
         sel_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         step_q  <= step_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state: step through select phases, sample at the settle point, publish once
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      step_d  = step_q;
      sel_d   = sel_q;
      sample  = 1'b0;
      publish = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_q == '0) begin
               state_d = ST_PHASE;
               ph_d    = '0;
               step_d  = '0;
               sel_d   = 1'b1;
            end
         end
         ST_PHASE: begin
            sample = (step_q == SAMPLE_STEP);
            if (step_q == STEP_LAST) begin
               step_d = '0;
               if (ph_q == PH_LAST) begin
                  state_d = ST_PUBLISH;
                  sel_d   = 1'b1;
               end else begin
                  ph_d  = ph_q + 1'b1;
                  // next phase is even (select high) exactly when this one is odd
                  sel_d = ph_q[0];
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         ST_PUBLISH: begin
            publish = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef GENESIS_SIX_BUTTON_EN
   logic six_q;
   logic six_out_q;
`endif

   // Shadow capture of the phase-dependent pin meanings
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q  <= '0;
         present_q <= 1'b0;
`ifdef GENESIS_SIX_BUTTON_EN
         six_q     <= 1'b0;
`endif
      end else if (sample) begin
         case (ph_q)
            PH_W'(0): begin
               shadow_q[BTN_UP]    <= pressed[PIN_UP];
               shadow_q[BTN_DOWN]  <= pressed[PIN_DOWN];
               shadow_q[BTN_LEFT]  <= pressed[PIN_LEFT];
               shadow_q[BTN_RIGHT] <= pressed[PIN_RIGHT];
               shadow_q[BTN_B]     <= pressed[PIN_AB];
               shadow_q[BTN_C]     <= pressed[PIN_SC];
            end
            PH_W'(1): begin
               shadow_q[BTN_A]     <= pressed[PIN_AB];
               shadow_q[BTN_START] <= pressed[PIN_SC];
               // a connected pad grounds left/right while select is low
               present_q           <= pressed[PIN_LEFT] & pressed[PIN_RIGHT];
            end
`ifdef GENESIS_SIX_BUTTON_EN
            PH_W'(5): begin
               six_q <= &pressed[PIN_RIGHT:PIN_UP];
            end
            PH_W'(6): begin
               shadow_q[BTN_Z]    <= six_q & pressed[PIN_UP];
               shadow_q[BTN_Y]    <= six_q & pressed[PIN_DOWN];
               shadow_q[BTN_X]    <= six_q & pressed[PIN_LEFT];
               shadow_q[BTN_MODE] <= six_q & pressed[PIN_RIGHT];
            end
`endif
            default: ;
         endcase
      end
   end

   // Published snapshot, valid strobe and presence flags
   always_ff @(posedge clk) begin
      if (reset) begin
         buttons_q     <= '0;
         valid_q       <= 1'b0;
         pad_present_q <= 1'b0;
`ifdef GENESIS_SIX_BUTTON_EN
         six_out_q     <= 1'b0;
`endif
      end else begin
         valid_q <= publish;
         if (publish) begin
            buttons_q     <= present_q ? shadow_q : '0;
            pad_present_q <= present_q;
`ifdef GENESIS_SIX_BUTTON_EN
            six_out_q     <= six_q & present_q;
`endif
         end
      end
   end

   assign pad.select_out    = sel_q;
   assign pad.buttons       = buttons_q;
   assign pad.buttons_valid = valid_q;
   assign pad.pad_present   = pad_present_q;
   assign pad.dbg_state     = state_q;
`ifdef GENESIS_SIX_BUTTON_EN
   assign pad.six_button    = six_out_q;
`else
   assign pad.six_button    = 1'b0;
`endif

endmodule

// File: tb/tb_genesis_pad_scanner.sv
// Bench for genesis_pad_scanner with STEP=8, SETTLE=4, FRAME=100. Uses a pad model
// (3- or 6-button) reacting to select_out. Honors GENESIS_SIX_BUTTON_EN.
module tb_genesis_pad_scanner;
   import genesis_pad_pkg::*;

   localparam int STEP  = 8;
   localparam int FRAME = 100;
`ifdef GENESIS_SIX_BUTTON_EN
   localparam int N = 8;
`else
   localparam int N = 2;
`endif
   localparam int FIRST_STROBE = STEP * N + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // cycle index since reset release: 0 in the cycle after the first active edge
   int cyc = -1;
   always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

   genesis_pad_scanner_if pad_if ();

   genesis_pad_scanner #(
      .STEP_CYCLES   (STEP),
      .SETTLE_CYCLES (4),
      .FRAME_CYCLES  (FRAME)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .pad   (pad_if)
   );

   // ---------------- pad model ----------------
   logic        m_conn  = 1'b0;
   logic        m_six   = 1'b0;
   logic [11:0] m_btn   = '0;
   logic        noise_en = 1'b0;
   logic [5:0]  noise   = '0;
   logic [5:0]  pin_model;   // {start_c, a_b, right, left_x, down_y, up_z}
   int          low_cnt = 0;
   int          hi_run  = 0;
   logic        prev_sel = 1'b1;

   // 6-button pads count select falling edges and reset after a long high period
   always @(negedge clk) begin
      if (rst) begin
         low_cnt  <= 0;
         hi_run   <= 0;
         prev_sel <= 1'b1;
      end else begin
         if (prev_sel && !pad_if.select_out) low_cnt <= low_cnt + 1;
         else if (hi_run > 20)               low_cnt <= 0;
         hi_run   <= pad_if.select_out ? hi_run + 1 : 0;
         prev_sel <= pad_if.select_out;
      end
   end

   always_comb begin
      pin_model = 6'h3F;
      if (m_conn) begin
         if (pad_if.select_out) begin
            if (m_six && low_cnt == 3)
               pin_model = {~m_btn[BTN_C], ~m_btn[BTN_B], ~m_btn[BTN_MODE], ~m_btn[BTN_X],
                            ~m_btn[BTN_Y], ~m_btn[BTN_Z]};
            else
               pin_model = {~m_btn[BTN_C], ~m_btn[BTN_B], ~m_btn[BTN_RIGHT], ~m_btn[BTN_LEFT],
                            ~m_btn[BTN_DOWN], ~m_btn[BTN_UP]};
         end else begin
            if (m_six && low_cnt == 3)
               pin_model = {~m_btn[BTN_START], ~m_btn[BTN_A], 4'b0000};
            else if (m_six && low_cnt == 4)
               pin_model = {~m_btn[BTN_START], ~m_btn[BTN_A], 4'b1111};
            else
               pin_model = {~m_btn[BTN_START], ~m_btn[BTN_A], 2'b00,
                            ~m_btn[BTN_DOWN], ~m_btn[BTN_UP]};
         end
      end
      pin_model = pin_model ^ noise;
   end

   assign pad_if.up_z    = pin_model[0];
   assign pad_if.down_y  = pin_model[1];
   assign pad_if.left_x  = pin_model[2];
   assign pad_if.right   = pin_model[3];
   assign pad_if.a_b     = pin_model[4];
   assign pad_if.start_c = pin_model[5];

   // Glitch generator: the DUT captures the raw pin present at edge 8*ph+2 of a scan
   // (2-flop synchronizer ahead of the step-3 sample), so the pins are held clean
   // only across that edge and scrambled everywhere else.
   always @(negedge clk) begin
      if (noise_en && cyc >= 0) begin
         if ((cyc % FRAME) < STEP * N && (cyc % FRAME) % STEP == 1) noise <= 6'h00;
         else noise <= 6'($urandom_range(0, 63));
      end else begin
         noise <= 6'h00;
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_strobe(output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (pad_if.buttons_valid === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL strobe_timeout: no buttons_valid within 200 cycles (cyc %0d)", cyc);
      end
   endtask

   typedef struct {
      string       name;
      bit          conn;
      bit          six;
      logic [11:0] held;
      logic [11:0] exp_btn;
      bit          exp_pres;
      bit          exp_six;
   } vec_t;

   vec_t vecs[$];

   // ---------------- test sequence ----------------
   initial begin
      int  at;
      int  last;
      bit  ok;
      bit  found;

      vecs.push_back('{"nopad",          1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0});
      vecs.push_back('{"a_up",           1'b1, 1'b0, 12'h011, 12'h011, 1'b1, 1'b0});
      vecs.push_back('{"start_c_right",  1'b1, 1'b0, 12'h0C8, 12'h0C8, 1'b1, 1'b0});
      vecs.push_back('{"many",           1'b1, 1'b0, 12'h0FD, 12'h0FD, 1'b1, 1'b0});
      vecs.push_back('{"none_held",      1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0});
      vecs.push_back('{"xyz_ignored",    1'b1, 1'b0, 12'hF01, 12'h001, 1'b1, 1'b0});
      vecs.push_back('{"unplugged_held", 1'b0, 1'b0, 12'h0FF, 12'h000, 1'b0, 1'b0});
`ifdef GENESIS_SIX_BUTTON_EN
      vecs.push_back('{"six_mode_start", 1'b1, 1'b1, 12'h880, 12'h880, 1'b1, 1'b1});
      vecs.push_back('{"six_zyx_a",      1'b1, 1'b1, 12'h710, 12'h710, 1'b1, 1'b1});
      vecs.push_back('{"six_none",       1'b1, 1'b1, 12'h000, 12'h000, 1'b1, 1'b1});
      vecs.push_back('{"three_after_six",1'b1, 1'b0, 12'hF01, 12'h001, 1'b1, 1'b0});
`endif

      // Reset values, then the select sequence of the first scan with no pad
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_select",  32'(pad_if.select_out),    32'h1);
      check("rst_buttons", 32'(pad_if.buttons),       32'h0);
      check("rst_valid",   32'(pad_if.buttons_valid), 32'h0);
      check("rst_present", 32'(pad_if.pad_present),   32'h0);
      check("rst_six",     32'(pad_if.six_button),    32'h0);
      rst = 1'b0;
      for (int c = 0; c <= FIRST_STROBE + 2; c++) begin
         @(negedge clk);
         check("scan1_select", 32'(pad_if.select_out),
               (c < STEP * N) ? 32'(((c / STEP) % 2) == 0) : 32'h1);
         check("scan1_valid", 32'(pad_if.buttons_valid), 32'(c == FIRST_STROBE));
      end
      check("scan1_buttons", 32'(pad_if.buttons),     32'h0);
      check("scan1_present", 32'(pad_if.pad_present), 32'h0);
      last = FIRST_STROBE;

      // Table: one scan per vector, model changed between scans
      foreach (vecs[i]) begin
         m_conn = vecs[i].conn;
         m_six  = vecs[i].six;
         m_btn  = vecs[i].held;
         wait_strobe(at, ok);
         if (ok) begin
            check({vecs[i].name, "_period"},  32'(at),                    32'(last + FRAME));
            check({vecs[i].name, "_buttons"}, 32'(pad_if.buttons),        32'(vecs[i].exp_btn));
            check({vecs[i].name, "_present"}, 32'(pad_if.pad_present),    32'(vecs[i].exp_pres));
            check({vecs[i].name, "_six"},     32'(pad_if.six_button),     32'(vecs[i].exp_six));
            last = at;
            @(negedge clk);
            check({vecs[i].name, "_strobe_w"}, 32'(pad_if.buttons_valid), 32'h0);
            check({vecs[i].name, "_hold"},     32'(pad_if.buttons),       32'(vecs[i].exp_btn));
         end
      end

      // Glitches away from the capture edges must not reach the snapshot
      m_conn   = 1'b1;
      m_six    = 1'b0;
      m_btn    = 12'h051;
      noise_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_strobe(at, ok);
         if (ok) begin
            check("noise_period",  32'(at),                  32'(last + FRAME));
            check("noise_buttons", 32'(pad_if.buttons),      32'h051);
            check("noise_present", 32'(pad_if.pad_present),  32'h1);
            last = at;
         end
      end
      noise_en = 1'b0;

      // Reset ten cycles into a scan aborts it; the scan restarts after release
      m_btn = 12'h011;
      wait_strobe(at, ok);
      if (ok) check("pre_rst_buttons", 32'(pad_if.buttons), 32'h011);
      found = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (cyc % FRAME == 10) begin
            found = 1'b1;
            break;
         end
      end
      check("midscan_reached", 32'(found), 32'h1);
      check("midscan_select_low", 32'(pad_if.select_out), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_select",  32'(pad_if.select_out),    32'h1);
      check("abort_buttons", 32'(pad_if.buttons),       32'h0);
      check("abort_present", 32'(pad_if.pad_present),   32'h0);
      check("abort_valid",   32'(pad_if.buttons_valid), 32'h0);
      repeat (2) begin
         @(negedge clk);
         check("abort_valid_hold", 32'(pad_if.buttons_valid), 32'h0);
      end
      rst = 1'b0;
      wait_strobe(at, ok);
      if (ok) begin
         check("restart_time",    32'(at),                 32'(FIRST_STROBE));
         check("restart_buttons", 32'(pad_if.buttons),     32'h011);
         check("restart_present", 32'(pad_if.pad_present), 32'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
